// File: rtl/pc_select_mux.sv
`default_nettype none
// ============================================================================
//  Module      : pc_select_mux
//  Description : Program-counter register with next-PC selection.
//                pc_plus_four = pc + 4 (wraps modulo 2^WIDTH).
//                mux_out      = branch_addr when mux_ctrl = 1, otherwise
//                               pc_plus_four (zero-cycle latency).
//                pc loads mux_out on every rising clk edge unless stall = 1.
//                The pc register is the only state in the block.
//
//  Ports       : clk          in   1      rising-edge clock
//                rst_n        in   1      asynchronous active-low reset
//                branch_addr  in   WIDTH  branch target (mux input 1)
//                mux_ctrl     in   1      0 = sequential, 1 = branch
//                stall        in   1      1 = hold pc
//                pc           out  WIDTH  registered program counter
//                pc_plus_four out  WIDTH  combinational pc + 4
//                mux_out      out  WIDTH  combinational next-PC selection
//                misalign     out  1      rejected misaligned branch target
//
//  Parameters  : WIDTH    (>= 2) datapath width of all address ports
//                RESET_PC value loaded into pc on reset
//
//  Build macro : PCMUX_ALIGN_CHECK_EN
//                defined   -> a selected branch target with nonzero bits
//                             [1:0] raises misalign and is rejected; the
//                             sequential address is taken instead.
//                undefined -> misalign tied low, branch_addr passed as-is.
//
//  Revision    : 1.0  initial release
// ============================================================================
module pc_select_mux #(
  parameter int unsigned       WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] branch_addr,
  input  logic             mux_ctrl,
  input  logic             stall,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_four,
  output logic [WIDTH-1:0] mux_out,
  output logic             misalign
);

  localparam logic [WIDTH-1:0] c_PC_INC = WIDTH'(4);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_plus_four;
  logic [WIDTH-1:0] w_mux_out;
  logic             w_misalign;
  logic             w_take_branch;

  // Carry out of the increment is intentionally dropped so the PC wraps.
  assign w_pc_plus_four = r_pc + c_PC_INC;

`ifdef PCMUX_ALIGN_CHECK_EN
  // A requested branch to a non-word-aligned target is refused; the
  // sequential address is used so the pipeline never fetches misaligned.
  assign w_misalign    = mux_ctrl & (|branch_addr[1:0]);
  assign w_take_branch = mux_ctrl & ~w_misalign;
`else
  assign w_misalign    = 1'b0;
  assign w_take_branch = mux_ctrl;
`endif

  // Any non-1 select value resolves to the sequential path.
  assign w_mux_out = w_take_branch ? branch_addr : w_pc_plus_four;

  // Stall has priority over a branch: a branch presented during a stall is
  // only taken if mux_ctrl is still high on the first non-stalled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (!stall) begin
      r_pc <= w_mux_out;
    end
  end

  assign pc           = r_pc;
  assign pc_plus_four = w_pc_plus_four;
  assign mux_out      = w_mux_out;
  assign misalign     = w_misalign;

endmodule
`default_nettype wire

// File: tb/tb_pc_select_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_select_mux
//  Description : Self-checking bench for pc_select_mux. Two instances share
//                the stimulus: one with RESET_PC = 0 and one with
//                RESET_PC = 0xFFFFFFFC (exercises the increment wrap).
//                Directed vectors are followed by randomized cycles with
//                asynchronous resets injected mid-cycle; every output is
//                compared against a behavioural model of the PC.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_select_mux;

  localparam int unsigned W     = 32;
  localparam logic [31:0] RST0  = 32'h0000_0000;
  localparam logic [31:0] RST1  = 32'hFFFF_FFFC;
`ifdef PCMUX_ALIGN_CHECK_EN
  localparam bit          ALIGN = 1'b1;
`else
  localparam bit          ALIGN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  branch_addr;
  logic          mux_ctrl;
  logic          stall;

  logic [W-1:0]  pc0, ppf0, mux0;
  logic          mis0;
  logic [W-1:0]  pc1, ppf1, mux1;
  logic          mis1;

  int n_err;
  int n_chk;

  // Behavioural model state: the expected PC of each instance.
  logic [31:0] m_pc0;
  logic [31:0] m_pc1;

  pc_select_mux #(.WIDTH(W), .RESET_PC(RST0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .branch_addr(branch_addr),
    .mux_ctrl(mux_ctrl), .stall(stall),
    .pc(pc0), .pc_plus_four(ppf0), .mux_out(mux0), .misalign(mis0)
  );

  pc_select_mux #(.WIDTH(W), .RESET_PC(RST1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .branch_addr(branch_addr),
    .mux_ctrl(mux_ctrl), .stall(stall),
    .pc(pc1), .pc_plus_four(ppf1), .mux_out(mux1), .misalign(mis1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference rules: a branch is rejected only when the alignment check is
  // built in and the target is not a multiple of four.
  function automatic bit exp_mis();
    return ALIGN && (mux_ctrl == 1'b1) && ((branch_addr % 4) != 0);
  endfunction

  function automatic logic [31:0] exp_next(input logic [31:0] p);
    logic [31:0] seq;
    seq = p + 32'd4;
    if ((mux_ctrl == 1'b1) && !exp_mis()) return branch_addr;
    return seq;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".pc0"},  pc0,  m_pc0);
    chk({tag, ".ppf0"}, ppf0, m_pc0 + 32'd4);
    chk({tag, ".mux0"}, mux0, exp_next(m_pc0));
    chk({tag, ".mis0"}, {31'd0, mis0}, {31'd0, exp_mis()});
    chk({tag, ".pc1"},  pc1,  m_pc1);
    chk({tag, ".ppf1"}, ppf1, m_pc1 + 32'd4);
    chk({tag, ".mux1"}, mux1, exp_next(m_pc1));
    chk({tag, ".mis1"}, {31'd0, mis1}, {31'd0, exp_mis()});
  endtask

  // Advance one rising edge, update the model, sample 1 ns later.
  task automatic step(input string tag);
    logic [31:0] n0, n1;
    n0 = exp_next(m_pc0);
    n1 = exp_next(m_pc1);
    @(posedge clk);
    if (!rst_n) begin
      m_pc0 = RST0;
      m_pc1 = RST1;
    end else if (!stall) begin
      m_pc0 = n0;
      m_pc1 = n1;
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic c, input logic [31:0] b, input logic s);
    mux_ctrl    = c;
    branch_addr = b;
    stall       = s;
    #1;
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    m_pc0 = RST0;
    m_pc1 = RST1;
    #1;
    check_all(tag);
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    rst_n = 1'b1;
    m_pc0 = 'x;
    m_pc1 = 'x;
    drive(1'b0, 32'h0, 1'b0);

    // Asynchronous reset in the middle of a cycle.
    #2;
    async_reset("rst");
    chk("rst.pc_const",  pc0,  32'h0000_0000);
    chk("rst.ppf_const", ppf0, 32'h0000_0004);
    step("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("rel");

    // Sequential counting and increment wrap on the second instance.
    step("seq1");
    chk("seq1.pc_const", pc0, 32'h4);
    chk("wrap.pc_const", pc1, 32'h0);
    step("seq2");
    chk("seq2.pc_const", pc0, 32'h8);
    step("seq3");
    chk("seq3.pc_const", pc0, 32'hC);

    // Branch: same-cycle mux_out, one-cycle load, then sequential again.
    drive(1'b1, 32'h40, 1'b0);
    chk("br.mux_const", mux0, 32'h40);
    step("br");
    chk("br.pc_const", pc0, 32'h40);
    drive(1'b0, 32'h40, 1'b0);
    step("br_seq");
    chk("br_seq.pc_const", pc0, 32'h44);

    // Stall beats a pending branch for two edges.
    drive(1'b1, 32'h10, 1'b0);
    step("to10");
    drive(1'b1, 32'h80, 1'b1);
    step("stall1");
    chk("stall1.pc_const", pc0, 32'h10);
    step("stall2");
    chk("stall2.pc_const", pc0, 32'h10);
    drive(1'b1, 32'h80, 1'b0);
    step("unstall");
    chk("unstall.pc_const", pc0, 32'h80);

    // Misaligned branch target.
    drive(1'b1, 32'h20, 1'b0);
    step("to20");
    drive(1'b1, 32'h42, 1'b0);
    chk("mis.flag_const", {31'd0, mis0}, ALIGN ? 32'd1 : 32'd0);
    step("mis");
    chk("mis.pc_const", pc0, ALIGN ? 32'h24 : 32'h42);

    // Reset during a stall with a pending branch.
    drive(1'b1, 32'h1000, 1'b1);
    #2;
    async_reset("rst_stall");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    step("post_rst");

    // Randomized cycles.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] b;
      b = $urandom;
      if ($urandom_range(0, 2) != 0) b[1:0] = 2'b00;
      drive(($urandom_range(0, 1) == 1), b, ($urandom_range(0, 3) == 0));
      check_all("rnd_comb");
      if ($urandom_range(0, 40) == 0) begin
        #($urandom_range(1, 2));
        async_reset("rnd_rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
      end else begin
        step("rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
